leaf_result_collector: RTL and testbench
========================================

Name: leaf_result_collector

Overview:
- Sits directly downstream of the per-node random-substitution PE array.
- Consumes each PE's 35-bit leaf result {address[2:0], nucl_alig[31:0]} and edge-detects it, since a PE holds a result for several cycles.
- Queues accepted results in a FIFO and streams them to the host/output interface over a valid/ready handshake.
- Tracks which leaves have reported and signals completion of the tree traversal.

Parameters:
FIFO_DEPTH, 8, result FIFO entries; power of two, 2..16
LEAF_MASK, 8'b1111_1110, bit i set = address i is an expected leaf; bit 0 must be 0 (address 0 means "no node")

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high; clears all state
result_in  input  35  PE leaf result {addr[34:32], seq[31:0]}; all-zero = no result
out_valid  output  1  head FIFO entry available
out_ready  input  1  consumer accepts head when out_valid=1
out_addr  output  3  leaf address of head entry
out_seq  output  32  16 nucleotides of head entry, 2 bits each (bits[1:0] = nucleotide 0)
fifo_count  output  $clog2(FIFO_DEPTH)+1  occupied entries
leaf_seen  output  8  bit i set once address i has been accepted
done  output  1  all expected leaves accepted and FIFO drained
overflow  output  1  sticky: result dropped because FIFO was full
dup_err  output  1  sticky: second distinct result for an already-seen leaf

Behaviour:
- Reset (synchronous, active-high, also mid-operation):
  - Flush the FIFO.
  - All outputs 0.
  - prev_result = 0; state = COLLECT.
- Capture qualifier, per cycle: cap = (result_in != 0) && (result_in[34:32] != 0) && (result_in != prev_result) && (state != DONE).
  - prev_result <= result_in every cycle.
  - A held result is therefore taken once.
  - A nonzero payload with address 0 is ignored silently.
- Duplicate rule: if cap and leaf_seen[addr]=1 -> not enqueued; dup_err <= 1.
- Enqueue: if cap, leaf not seen, and (count < FIFO_DEPTH or pop this cycle) -> write the entry and set leaf_seen[addr].
- Full rule: if cap with FIFO full and no pop -> drop; overflow <= 1; leaf_seen is NOT set.
- Pop: out_valid && out_ready; pointer advances.
- FIFO is first-word-fall-through:
  - out_addr/out_seq show the head combinationally from storage.
  - When empty, out_valid=0 and out_addr/out_seq are driven 0.
- Latency: result_in sampled at edge N -> out_valid=1 after edge N (visible in cycle N+1).
- Handshake:
  - The consumer may hold out_ready high continuously.
  - The head is stable while out_valid=1 && out_ready=0.
- Simultaneous push and pop:
  - When full: both succeed; count unchanged.
  - When empty: the push is taken and the pop is not, since out_valid was 0.
- Pointers wrap modulo FIFO_DEPTH; count is saturation-free by construction.
- State machine:
  - COLLECT: accepts results. Moves to DRAIN when (leaf_seen & LEAF_MASK) == LEAF_MASK, evaluated on next-state leaf_seen.
  - DRAIN: still accepts captures for addresses outside LEAF_MASK; a duplicate still sets dup_err. Moves to DONE when count becomes 0 with no push pending.
  - DONE: done=1; all captures ignored, including flags. Only reset leaves DONE.
- done is registered; it asserts the cycle after the last pop.
- Flags (overflow, dup_err, leaf_seen) are sticky until reset.

Test Plan:
- Hold result_in=35'h1_0000_00E4 (addr 1) for 3 cycles -> exactly one entry; fifo_count=1; out_addr=1, out_seq=32'h0000_00E4; leaf_seen=8'h02.
- LEAF_MASK=8'h06; results addr2 seq=32'hAAAA_AAAA, then addr1 seq=32'h5555_5555; out_ready=1 -> pops in order addr2 then addr1; state DRAIN then DONE; done=1 one cycle after the second pop.
- out_ready=0; push FIFO_DEPTH distinct addresses (depth 4, addrs 1..4), then addr 5 -> fifo_count=4; overflow=1; leaf_seen[5]=0. Next: full plus a simultaneous pop and push of addr 6 -> count stays 4; addr 6 accepted.
- addr3 seq=1, then zero, then addr3 seq=2 -> second result rejected; dup_err=1; one entry only.
- Stall: out_valid=1 with out_ready=0 for 5 cycles -> out_addr/out_seq unchanged. Assert reset mid-stream -> next cycle out_valid=0, fifo_count=0, all flags 0, done=0.
- result_in={3'b000, 32'hFFFF_FFFF} -> ignored; no flags set; FIFO stays empty.

Source files
------------

// File: rtl/leaf_result_collector.sv
// Leaf result collector: edge-detects held PE leaf results, queues accepted
// results in a first-word-fall-through FIFO, streams them out over
// valid/ready and signals when every expected leaf has reported and drained.
module leaf_result_collector #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [7:0]  LEAF_MASK  = 8'b1111_1110
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [34:0]                     result_in,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [2:0]                      out_addr,
    output logic [31:0]                     out_seq,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic [7:0]                      leaf_seen,
    output logic                            done,
    output logic                            overflow,
    output logic                            dup_err
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StCollect, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [34:0]       prev_q, prev_d;
    logic [34:0]       mem_q [FIFO_DEPTH];
    logic [34:0]       mem_d [FIFO_DEPTH];
    logic [PtrW-1:0]   wptr_q, wptr_d;
    logic [PtrW-1:0]   rptr_q, rptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [7:0]        seen_q, seen_d;
    logic              ovf_q, ovf_d;
    logic              dup_q, dup_d;
    logic              done_q, done_d;

    logic [2:0]        in_addr;
    logic              cap, is_seen, full, push, pop;

    // Capture qualification, FIFO bookkeeping, flags and traversal state.
    always_comb begin
        in_addr = result_in[34:32];
        pop     = (count_q != '0) && out_ready;
        // A PE holds its result for several cycles; only a change is a new result.
        cap     = (result_in != '0) && (in_addr != 3'd0) && (result_in != prev_q)
                  && (state_q != StDone);
        is_seen = seen_q[in_addr];
        full    = (count_q == CntW'(FIFO_DEPTH));
        push    = cap && !is_seen && (!full || pop);

        dup_d   = dup_q | (cap && is_seen);
        ovf_d   = ovf_q | (cap && !is_seen && full && !pop);
        seen_d  = seen_q | (push ? (8'd1 << in_addr) : 8'd0);
        prev_d  = result_in;

        wptr_d  = wptr_q + PtrW'(push);
        rptr_d  = rptr_q + PtrW'(pop);
        count_d = count_q + CntW'(push) - CntW'(pop);

        mem_d = mem_q;
        if (push) begin
            mem_d[wptr_q] = result_in;
        end

        state_d = state_q;
        unique case (state_q)
            StCollect: if ((seen_d & LEAF_MASK) == LEAF_MASK) state_d = StDrain;
            StDrain:   if (count_d == '0) state_d = StDone;
            StDone:    state_d = StDone;
            default:   state_d = StCollect;
        endcase
        done_d = (state_d == StDone);
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StCollect;
            prev_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            seen_q  <= '0;
            ovf_q   <= 1'b0;
            dup_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            seen_q  <= seen_d;
            ovf_q   <= ovf_d;
            dup_q   <= dup_d;
            done_q  <= done_d;
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Head of the FIFO falls through combinationally; zeroed when empty.
    always_comb begin
        out_valid  = (count_q != '0);
        out_addr   = out_valid ? mem_q[rptr_q][34:32] : 3'd0;
        out_seq    = out_valid ? mem_q[rptr_q][31:0] : 32'd0;
        fifo_count = count_q;
        leaf_seen  = seen_q;
        done       = done_q;
        overflow   = ovf_q;
        dup_err    = dup_q;
    end

endmodule

// File: tb/tb_leaf_result_collector.sv
// Self-checking bench for leaf_result_collector: directed scenarios followed by
// randomized traffic, all compared against a queue-based behavioural model.
module tb_leaf_result_collector;

    localparam int unsigned DEPTH = 4;
    localparam logic [7:0]  MASK  = 8'h06;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [34:0] result_in = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [2:0]  out_addr;
    logic [31:0] out_seq;
    logic [2:0]  fifo_count;
    logic [7:0]  leaf_seen;
    logic        done;
    logic        overflow;
    logic        dup_err;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [34:0] mq[$];
    logic [7:0]  mseen;
    logic        movf, mdup;
    int          mphase;        // 0 collecting, 1 draining, 2 finished
    logic [34:0] mprev;

    leaf_result_collector #(
        .FIFO_DEPTH (DEPTH),
        .LEAF_MASK  (MASK)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .result_in  (result_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_seq    (out_seq),
        .fifo_count (fifo_count),
        .leaf_seen  (leaf_seen),
        .done       (done),
        .overflow   (overflow),
        .dup_err    (dup_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of the reference behaviour, applied with the inputs of that cycle.
    task automatic model_step(input logic [34:0] r, input logic rdy, input logic rst);
        bit pop, cap, push;
        int a;
        if (rst) begin
            mq.delete();
            mseen = '0; movf = 0; mdup = 0; mphase = 0; mprev = '0;
            return;
        end
        a    = int'(r[34:32]);
        pop  = (mq.size() > 0) && rdy;
        cap  = (r != 0) && (a != 0) && (r != mprev) && (mphase != 2);
        push = 0;
        if (cap) begin
            if (mseen[a]) mdup = 1;
            else if (mq.size() < DEPTH || pop) push = 1;
            else movf = 1;
        end
        if (pop) void'(mq.pop_front());
        if (push) begin
            mq.push_back(r);
            mseen[a] = 1'b1;
        end
        if (mphase == 0 && (mseen & MASK) == MASK) mphase = 1;
        else if (mphase == 1 && mq.size() == 0) mphase = 2;
        mprev = r;
    endtask

    task automatic compare_all();
        logic [34:0] head;
        head = (mq.size() > 0) ? mq[0] : 35'd0;
        chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
        chk("out_addr", 64'(out_addr), 64'(head[34:32]));
        chk("out_seq", 64'(out_seq), 64'(head[31:0]));
        chk("fifo_count", 64'(fifo_count), 64'(mq.size()));
        chk("leaf_seen", 64'(leaf_seen), 64'(mseen));
        chk("done", 64'(done), 64'(mphase == 2));
        chk("overflow", 64'(overflow), 64'(movf));
        chk("dup_err", 64'(dup_err), 64'(mdup));
    endtask

    task automatic step(input logic [34:0] r, input logic rdy, input logic rst);
        result_in = r;
        out_ready = rdy;
        reset     = rst;
        @(posedge clk);
        model_step(r, rdy, rst);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        step(35'd0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [34:0] r, last_r;
        logic [31:0] hold_seq;
        logic [2:0]  hold_addr;

        mq.delete();
        mseen = '0; movf = 0; mdup = 0; mphase = 0; mprev = '0;

        // Reset state
        do_reset();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);

        // Held result taken once
        for (int i = 0; i < 3; i++) step(35'h1_0000_00E4, 1'b0, 1'b0);
        chk("hold_count", 64'(fifo_count), 64'd1);
        chk("hold_addr", 64'(out_addr), 64'd1);
        chk("hold_seq", 64'(out_seq), 64'h0000_00E4);
        chk("hold_seen", 64'(leaf_seen), 64'h02);

        // Ordered drain to completion with mask 8'h06
        do_reset();
        step({3'd2, 32'hAAAA_AAAA}, 1'b1, 1'b0);
        chk("ord_head2", 64'(out_addr), 64'd2);
        step({3'd1, 32'h5555_5555}, 1'b1, 1'b0);
        chk("ord_head1", 64'(out_addr), 64'd1);
        chk("ord_notdone", 64'(done), 64'd0);
        step(35'd0, 1'b1, 1'b0);
        chk("ord_done", 64'(done), 64'd1);
        step(35'd0, 1'b1, 1'b0);
        step({3'd5, 32'h1234}, 1'b1, 1'b0);   // ignored once done
        chk("ord_ignore", 64'(fifo_count), 64'd0);

        // Overflow and full push+pop
        do_reset();
        for (int a = 1; a <= 4; a++) step({3'(a), 32'(a * 16)}, 1'b0, 1'b0);
        step({3'd5, 32'h50}, 1'b0, 1'b0);
        chk("ovf_count", 64'(fifo_count), 64'd4);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_seen5", 64'(leaf_seen[5]), 64'd0);
        step({3'd6, 32'h60}, 1'b1, 1'b0);
        chk("full_pp_count", 64'(fifo_count), 64'd4);
        chk("full_pp_seen6", 64'(leaf_seen[6]), 64'd1);
        for (int i = 0; i < 6; i++) step(35'd0, 1'b1, 1'b0);

        // Duplicate rejection
        do_reset();
        step({3'd3, 32'd1}, 1'b0, 1'b0);
        step(35'd0, 1'b0, 1'b0);
        step({3'd3, 32'd2}, 1'b0, 1'b0);
        chk("dup_flag", 64'(dup_err), 64'd1);
        chk("dup_count", 64'(fifo_count), 64'd1);

        // Stall then mid-stream reset
        do_reset();
        step({3'd4, 32'hDEAD_BEEF}, 1'b0, 1'b0);
        step({3'd7, 32'h0BAD_F00D}, 1'b0, 1'b0);
        hold_addr = out_addr;
        hold_seq  = out_seq;
        for (int i = 0; i < 5; i++) begin
            step(35'd0, 1'b0, 1'b0);
            chk("stall_addr", 64'(out_addr), 64'(hold_addr));
            chk("stall_seq", 64'(out_seq), 64'(hold_seq));
        end
        step({3'd3, 32'd9}, 1'b0, 1'b1);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_seen", 64'(leaf_seen), 64'd0);

        // Address 0 payload ignored
        do_reset();
        step({3'd0, 32'hFFFF_FFFF}, 1'b1, 1'b0);
        step({3'd0, 32'hFFFF_FFFF}, 1'b1, 1'b0);
        chk("a0_count", 64'(fifo_count), 64'd0);
        chk("a0_flags", 64'({overflow, dup_err, leaf_seen}), 64'd0);

        // Randomized traffic
        do_reset();
        last_r = '0;
        for (int i = 0; i < 600; i++) begin
            int k;
            k = int'($urandom_range(0, 9));
            if (k < 2) r = '0;
            else if (k < 4) r = last_r;
            else r = {3'($urandom_range(0, 7)), 32'($urandom_range(0, 3))};
            last_r = r;
            step(r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 59) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
